ysyx_22041207_muldiv: RTL and testbench
=======================================

# ysyx_22041207_muldiv

Iterative multiply/divide unit for the ysyx_22041207 RV64 core. It executes the M-extension operations that the decoder marks as `ALU_MUL`, `ALU_DIV`, `ALU_DIVU`, `ALU_REM` and `ALU_REMU`, in both 64-bit and W (32-bit) forms. It sits beside the single-cycle ALU in EXU and talks to the pipeline over a valid/ready handshake, so EXU can stall while an operation is in flight. It owns the sequencing state machine, the operand sign preparation, the special-case detection and the result correction.

## Interface
- `XLEN`, default 64: datapath width. Word mode always operates on 32 bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request; high only in IDLE.
- `op` input 3: operation select. 0 = MUL, 1 = DIV, 2 = DIVU, 3 = REM, 4 = REMU. Values 5–7 are treated as MUL.
- `word` input 1: W variant (mulw, divw, divuw, remw, remuw).
- `src_a` input XLEN: rs1 value (multiplicand or dividend).
- `src_b` input XLEN: rs2 value (multiplier or divisor).
- `tag_in` input 5: rd address, carried through to the output.
- `flush` input 1: abort the operation in flight (branch or trap redirect).
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output XLEN: final value, already sign-extended in word mode.
- `tag_out` output 5: the tag captured at accept.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - The unit accepts a request when `in_valid && in_ready && !flush`.
  - On accept it latches the operands, `op`, `word` and the tag.
  - It computes `N` = 32 if `word` is set, else XLEN.
  - It moves to CALC, or to DONE for special cases.
- **Operand preparation:**
  - In word mode only the low 32 bits of each operand are used.
  - Signed ops (MUL, DIV, REM) take the absolute value of each operand and record the sign of the quotient/product (signs differ) and of the remainder (sign of the dividend).
  - Unsigned ops use the operands zero-extended.
- **CALC, multiply:** radix-2 shift-add, one multiplier bit per cycle, `N` cycles. Only the low `N` bits of the product are kept.
- **CALC, divide:** restoring shift-subtract, one quotient bit per cycle, `N` cycles. It produces the unsigned quotient and remainder.
- **Iteration counter:** 7 bits, loaded with `N-1`, decremented every CALC cycle. CALC exits to FIX in the cycle the counter reads 0.
- **FIX:**
  - Negate the quotient/product and/or the remainder as recorded at accept.
  - Select the quotient or the remainder according to `op`.
  - In word mode, sign-extend bit 31 to XLEN. This applies to all W ops, including divuw and remuw.
  - Then go to DONE.
- **Special cases** (go straight from IDLE to DONE, no iteration):
  - Divide by zero (`src_b` = 0 in the effective width):
    - DIV/DIVU return all ones. In word mode this is 0xFFFFFFFF sign-extended, i.e. all ones.
    - REM/REMU return the dividend (word mode: sign-extended low 32 bits).
  - Signed overflow (dividend = most negative value, divisor = -1, in the effective width):
    - DIV returns the dividend (sign-extended in word mode).
    - REM returns 0.
- **DONE:**
  - `out_valid` = 1, and `result` and `tag_out` are held stable.
  - When `out_ready` is sampled high, the unit returns to IDLE.
- **flush:**
  - Highest priority below `rst`.
  - From any state the unit goes to IDLE on the next edge, and `out_valid` goes low that edge.
  - A request presented in the same cycle as `flush` is not accepted.
- **rst:**
  - State goes to IDLE, the counter to 0, and every output register clears: `result` = 0, `tag_out` = 0, `out_valid` = 0, `busy` = 0.
  - `in_ready` = 1 in the first cycle after reset.
  - Reset mid-operation discards the operation silently.

## Timing
- Let T be the accept edge.
- **Iterative path:** CALC occupies cycles T+1 .. T+N, FIX is at T+N+1, and `out_valid` rises at T+N+2.
  - This is 66 cycles for 64-bit ops and 34 cycles for W ops.
- **Special cases:** `out_valid` rises at T+1.
- **No back-to-back overlap:** `in_ready` is low from T+1 until the edge after the output handshake. The earliest next accept is the cycle after `out_valid && out_ready`.
- **Outputs:** `in_ready` and `busy` are decoded from state. `out_valid`, `result` and `tag_out` are registered.
- **Stability:** `result` does not change while `out_valid && !out_ready`.

## Configuration
- **`YSYX_22041207_MUL_FAST_EN` defined:**
  - MUL ops are computed in IDLE→DONE with a single-cycle `*` (low `N` bits, sign-extended in word mode).
  - `out_valid` rises at T+1 and CALC is never entered for MUL.
  - Divide timing is unchanged.
- **Macro undefined:** MUL uses the iterative shift-add path with the timing given above.

## Test plan
- **64-bit MUL:** `op`=0, `word`=0, `src_a`=7, `src_b`=0xFFFFFFFFFFFFFFFD → `result` = 0xFFFFFFFFFFFFFFEB. `out_valid` at T+66, or at T+1 with `YSYX_22041207_MUL_FAST_EN`.
- **Signed DIV/REM:** DIV -7/2 → 0xFFFFFFFFFFFFFFFD. REM -7/2 → 0xFFFFFFFFFFFFFFFF. Both at T+66.
- **Divide by zero:** DIVU 0x1234/0 → all ones. REM 0x1234/0 → 0x1234. Both at T+1, CALC never entered.
- **Word overflow and divuw:**
  - `word`=1, DIV with `src_a`=0x80000000 and `src_b`=0xFFFFFFFF → 0xFFFFFFFF80000000; REM on the same operands → 0.
  - DIVU `word`=1 with 0xFFFFFFFE/1 → 0xFFFFFFFFFFFFFFFE at T+34.
- **Backpressure:** hold `out_ready` low for 5 cycles after `out_valid` → `result` and `tag_out` stable and `in_ready` low throughout. The next request is accepted in the cycle after the handshake.
- **Abort:**
  - Assert `flush` at T+10 of a DIV → IDLE with `in_ready` = 1 at T+11, and `out_valid` never asserts.
  - Repeat with `rst` instead of `flush` → all outputs 0.
  - `in_valid` together with `flush` in IDLE → request not accepted.

Source files
------------

// File: rtl/ysyx_22041207_muldiv.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_muldiv
//   Iterative multiply/divide unit for the RV64 M extension (MUL, DIV, DIVU,
//   REM, REMU and their W forms). It sits beside the single-cycle ALU in EXU.
//   Multiply is radix-2 shift-add. Divide is restoring shift-subtract. Both
//   take one bit per cycle over N = 32 (word) or XLEN cycles.
//
//   Optional feature macro: YSYX_22041207_MUL_FAST_EN
//     When defined, MUL is computed in one cycle with '*' and skips CALC.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (in_ready high only in IDLE)
//   op, word     : 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU (5-7 = MUL); W variant
//   src_a, src_b : rs1 / rs2 operands
//   tag_in       : rd address, returned on tag_out with the result
//   flush        : abort whatever is in flight, back to IDLE
//   out_valid/out_ready : result handshake
//   result       : final value (sign-extended from bit 31 in word mode)
//   tag_out      : tag captured at accept
//   busy         : high in any state other than IDLE
//   dbg_state    : current FSM state, for debug and assertion binding
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_valid is ignored in a cycle where flush is high.
// Once out_valid is high, result and tag_out hold until the edge on which
// out_ready is sampled high.
// ---------------------------------------------------------------------------
module ysyx_22041207_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      tag_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      tag_out,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    localparam logic [XLEN-1:0] W_MASK    = {{(XLEN-32){1'b0}}, {32{1'b1}}};
    localparam logic [XLEN-1:0] MIN_NEG_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_NEG_W = {{(XLEN-32){1'b0}}, 1'b1, 31'b0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q;
    logic [6:0]      cnt_q;
    logic [2:0]      op_q;
    logic            word_q;
    logic [XLEN-1:0] a_q;          // multiplicand (shifts left) / dividend+quotient
    logic [XLEN-1:0] b_q;          // multiplier (shifts right) / divisor
    logic [XLEN-1:0] acc_q;        // product accumulator / partial remainder
    logic            neg_q_q;      // negate quotient or product in FIX
    logic            neg_r_q;      // negate remainder in FIX
    logic [XLEN-1:0] result_q;
    logic [4:0]      tag_out_q;
    logic            out_valid_q;

    // Sign-extend bit 31 when w is set, otherwise pass through.
    function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] x);
        return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    // ---------------- accept-side operand preparation ----------------
    logic            sgn_op_in;
    logic            is_div_in;
    logic [XLEN-1:0] wmask;
    logic [XLEN-1:0] a_eff_d, b_eff_d;
    logic            a_neg_d, b_neg_d;
    logic [XLEN-1:0] a_abs_d, b_abs_d;
    logic            b_zero_d, ovf_d, special_d;
    logic [XLEN-1:0] spec_res_d;
    logic [XLEN-1:0] a_load_d;

    always_comb begin
        sgn_op_in = !(op == OP_DIVU || op == OP_REMU);
        is_div_in = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        wmask     = word ? W_MASK : {XLEN{1'b1}};
        a_eff_d   = src_a & wmask;
        b_eff_d   = src_b & wmask;
        a_neg_d   = sgn_op_in & (word ? src_a[31] : src_a[XLEN-1]);
        b_neg_d   = sgn_op_in & (word ? src_b[31] : src_b[XLEN-1]);
        // Two's-complement magnitude, re-masked so word mode stays 32 bits wide.
        a_abs_d   = a_neg_d ? (({XLEN{1'b0}} - a_eff_d) & wmask) : a_eff_d;
        b_abs_d   = b_neg_d ? (({XLEN{1'b0}} - b_eff_d) & wmask) : b_eff_d;

        b_zero_d  = (b_eff_d == {XLEN{1'b0}});
        ovf_d     = (op == OP_DIV || op == OP_REM) &&
                    (a_eff_d == (word ? MIN_NEG_W : MIN_NEG_D)) &&
                    (b_eff_d == wmask);
        special_d = is_div_in && (b_zero_d || ovf_d);

        spec_res_d = {XLEN{1'b0}};
        if (b_zero_d) begin
            spec_res_d = (op == OP_DIV || op == OP_DIVU) ? {XLEN{1'b1}} : sext_w(word, a_eff_d);
        end else if (op == OP_DIV) begin
            spec_res_d = sext_w(word, a_eff_d);
        end

        // The divider always consumes a_q from bit XLEN-1, so a word dividend
        // is parked in the upper half. After 32 shifts the quotient sits in
        // the low half with zeros above it.
        a_load_d = (is_div_in && word) ? (a_abs_d << 32) : a_abs_d;
    end

`ifdef YSYX_22041207_MUL_FAST_EN
    logic [XLEN-1:0] fast_prod_d;
    always_comb begin
        fast_prod_d = src_a * src_b;
    end
`endif

    // ---------------- iteration step ----------------
    logic            is_div_q;
    logic [XLEN-1:0] mul_acc_d;
    logic [XLEN:0]   rem_sh_d;
    logic [XLEN:0]   rem_sub_d;
    logic            div_ge_d;

    always_comb begin
        is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_REM) || (op_q == OP_REMU);
        mul_acc_d = acc_q + (b_q[0] ? a_q : {XLEN{1'b0}});
        // The partial remainder stays below the divisor, so the shifted value
        // fits in XLEN+1 bits. The top bit of the difference is the borrow.
        rem_sh_d  = {acc_q, a_q[XLEN-1]};
        rem_sub_d = rem_sh_d - {1'b0, b_q};
        div_ge_d  = ~rem_sub_d[XLEN];
    end

    // ---------------- result correction ----------------
    logic [XLEN-1:0] q_fix_d, r_fix_d, p_fix_d, fix_res_d;

    always_comb begin
        q_fix_d = neg_q_q ? ({XLEN{1'b0}} - a_q)   : a_q;
        r_fix_d = neg_r_q ? ({XLEN{1'b0}} - acc_q) : acc_q;
        p_fix_d = neg_q_q ? ({XLEN{1'b0}} - acc_q) : acc_q;
        case (op_q)
            OP_DIV, OP_DIVU: fix_res_d = q_fix_d;
            OP_REM, OP_REMU: fix_res_d = r_fix_d;
            default:         fix_res_d = p_fix_d;
        endcase
        fix_res_d = sext_w(word_q, fix_res_d);
    end

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 7'd0;
            op_q        <= 3'd0;
            word_q      <= 1'b0;
            a_q         <= {XLEN{1'b0}};
            b_q         <= {XLEN{1'b0}};
            acc_q       <= {XLEN{1'b0}};
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            result_q    <= {XLEN{1'b0}};
            tag_out_q   <= 5'd0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q      <= op;
                        word_q    <= word;
                        tag_out_q <= tag_in;
                        cnt_q     <= word ? 7'd31 : 7'(XLEN - 1);
                        neg_q_q   <= a_neg_d ^ b_neg_d;
                        neg_r_q   <= a_neg_d;
                        acc_q     <= {XLEN{1'b0}};
                        a_q       <= a_load_d;
                        b_q       <= b_abs_d;
                        if (special_d) begin
                            result_q    <= spec_res_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
`ifdef YSYX_22041207_MUL_FAST_EN
                        else if (!is_div_in) begin
                            result_q    <= sext_w(word, fast_prod_d);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
`endif
                        else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (is_div_q) begin
                        acc_q <= div_ge_d ? rem_sub_d[XLEN-1:0] : rem_sh_d[XLEN-1:0];
                        a_q   <= {a_q[XLEN-2:0], div_ge_d};
                    end else begin
                        acc_q <= mul_acc_d;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end
                    if (cnt_q == 7'd0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                S_FIX: begin
                    result_q    <= fix_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_22041207_muldiv.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_22041207_muldiv. A reference model computes results
// with plain signed/unsigned arithmetic. It computes latency from the
// operation class. A negedge compare process checks every valid output
// against the queue of expected results.
// ---------------------------------------------------------------------------
module tb_ysyx_22041207_muldiv;
  localparam int XLEN = 64;

  logic        clk, rst, in_valid, in_ready, word, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] src_a, src_b, result;
  logic [4:0]  tag_in, tag_out;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;
  logic [63:0] exp_q[$];
  logic [4:0]  exp_tag_q[$];

  ysyx_22041207_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src_a(src_a), .src_b(src_b), .tag_in(tag_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    r32 = 32'd0; r = 64'd0;
    if (w) begin
      case (o)
        3'd1: if (b32 == 0) r32 = 32'hFFFFFFFF;
              else if (a32 == 32'h80000000 && b32 == 32'hFFFFFFFF) r32 = a32;
              else r32 = 32'(sa32 / sb32);
        3'd2: r32 = (b32 == 0) ? 32'hFFFFFFFF : a32 / b32;
        3'd3: if (b32 == 0) r32 = a32;
              else if (a32 == 32'h80000000 && b32 == 32'hFFFFFFFF) r32 = 32'd0;
              else r32 = 32'(sa32 % sb32);
        3'd4: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        3'd1: if (b == 0) r = '1;
              else if (a == 64'h8000000000000000 && b == '1) r = a;
              else r = 64'(sa / sb);
        3'd2: r = (b == 0) ? '1 : a / b;
        3'd3: if (b == 0) r = a;
              else if (a == 64'h8000000000000000 && b == '1) r = 64'd0;
              else r = 64'(sa % sb);
        3'd4: r = (b == 0) ? a : a % b;
        default: r = a * b;
      endcase
    end
    return r;
  endfunction

  // Cycle index (accept = T) at which out_valid is first seen.
  function automatic int model_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    int n;
    logic bz, ovf, is_div;
    n = w ? 32 : 64;
    is_div = (o >= 3'd1) && (o <= 3'd4);
    bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf = (o == 3'd1 || o == 3'd3) &&
          (w ? (a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF)
             : (a == 64'h8000000000000000 && b == '1));
    if (is_div) return (bz || ovf) ? 1 : n + 2;
`ifdef YSYX_22041207_MUL_FAST_EN
    return 1;
`else
    return n + 2;
`endif
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'($urandom_range(1, 20));
      2: return '1;
      3: return 64'h8000000000000000;
      4: return {$urandom, 32'h80000000};
      5: return 64'd0 - 64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got out_valid=1 result %h, required no output", result);
      end else begin
        check("result", result, exp_q[0]);
        check("tag_out", 64'(tag_out), 64'(exp_tag_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int bp, input string name);
    int lat, exp_lat;
    logic [4:0] t;
    t = 5'($urandom_range(0, 31));
    exp_lat = model_lat(o, w, a, b);
    check({name, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    op = o; word = w; src_a = a; src_b = b; tag_in = t; in_valid = 1'b1;
    exp_q.push_back(model_result(o, w, a, b));
    exp_tag_q.push_back(t);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); word = 1'($urandom); src_a = {$urandom, $urandom};
    src_b = {$urandom, $urandom}; tag_in = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (!out_valid) begin
      exp_q.delete();
      exp_tag_q.delete();
    end
    check({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
    repeat (bp) begin
      @(posedge clk); #1;
      check({name, "_bp_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic seen;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; word = 1'b0; src_a = 64'd0; src_b = 64'd0;
    tag_in = 5'd0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_tag_out", 64'(tag_out), 64'd0);

    // Hand-computed values that pin the model.
    check("pin_mul", model_result(3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD), 64'hFFFFFFFFFFFFFFEB);
    check("pin_div", model_result(3'd1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2), 64'hFFFFFFFFFFFFFFFD);
    check("pin_rem", model_result(3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2), 64'hFFFFFFFFFFFFFFFF);
    check("pin_divuw", model_result(3'd2, 1'b1, 64'hFFFFFFFE, 64'd1), 64'hFFFFFFFFFFFFFFFE);
    check("pin_divw_ovf", model_result(3'd1, 1'b1, 64'h80000000, 64'hFFFFFFFF), 64'hFFFFFFFF80000000);

    // Directed cases.
    run_op(3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 0, "mul64");
    run_op(3'd1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 0, "div_neg");
    run_op(3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 0, "rem_neg");
    run_op(3'd2, 1'b0, 64'h1234, 64'd0, 0, "divu_zero");
    run_op(3'd3, 1'b0, 64'h1234, 64'd0, 0, "rem_zero");
    run_op(3'd1, 1'b1, 64'h80000000, 64'hFFFFFFFF, 0, "divw_ovf");
    run_op(3'd3, 1'b1, 64'h80000000, 64'hFFFFFFFF, 0, "remw_ovf");
    run_op(3'd1, 1'b0, 64'h8000000000000000, '1, 0, "div64_ovf");
    run_op(3'd0, 1'b1, 64'hDEAD0000FFFFFFFF, 64'hBEEF000000000003, 2, "mulw_junk");
    run_op(3'd4, 1'b1, 64'h12345678_00000064, 64'h0, 1, "remuw_zero");
    run_op(3'd1, 1'b0, 64'd1000, 64'd7, 5, "div_bp");
    run_op(3'd2, 1'b1, 64'hFFFFFFFE, 64'd1, 0, "divuw");

    // Flush during a DIV in cycle T+10.
    op = 3'd1; word = 1'b0; src_a = 64'd1000; src_b = 64'd7; tag_in = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Request together with flush in IDLE is dropped.
    op = 3'd2; word = 1'b0; src_a = 64'd55; src_b = 64'd0; tag_in = 5'd9;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_req_no_valid", 64'(seen), 64'd0);

    // Reset in the middle of a DIV clears every output register.
    op = 3'd1; word = 1'b0; src_a = 64'd999; src_b = 64'd4; tag_in = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_tag_out", 64'(tag_out), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rand_val(), rand_val(),
             $urandom_range(0, 3), "rand");
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
